// File: rtl/mdu_responder_if.sv
// Start/busy handshake between the EX stage (master) and the multiply/divide responder (slave).
interface mdu_responder_if;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operation;
  logic        start;
  logic        hilo_write;
  logic        busy;
  logic [31:0] dataRead;

  modport master (
    output operand1, operand2, operation, start, hilo_write,
    input  busy, dataRead
  );

  modport slave (
    input  operand1, operand2, operation, start, hilo_write,
    output busy, dataRead
  );
endinterface

// File: rtl/mdu_responder.sv
// Multiply/divide responder holding HI/LO; MULT/DIV run under a busy period, MFHI/MFLO read combinationally.
// Build option: define MDU_ITERATIVE_DIV_EN for a 32-cycle radix-2 restoring divider instead of the fixed-latency one.
module mdu_responder #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clock,
  input logic            reset,
  mdu_responder_if.slave bus
);

  localparam int DATA_W = 32;
`ifdef MDU_ITERATIVE_DIV_EN
  localparam int DIV_N = DATA_W;
`else
  localparam int DIV_N = DIV_CYCLES;
`endif
  localparam int MAX_A = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MAX_N = (MAX_A > DIV_N) ? MAX_A : DIV_N;
  localparam int CNT_W = $clog2(MAX_N) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_N - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                launch, commit;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   a_p1, b_p1;
  logic                signed_p1;
  logic signed [63:0]  mul_a, mul_b, prod;
  logic [DATA_W-1:0]   div_hi, div_lo;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                div_zero, div_ovf;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Control: IDLE accepts start; MUL/DIV count down and commit on the cycle the counter hits zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    launch  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.operation[2]) begin
          launch  = 1'b1;
          state_n = bus.operation[1] ? DIV : MUL;
          cnt_n   = bus.operation[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      MUL, DIV: begin
        if (cnt == '0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // p1: operands and signedness captured only at the start edge
  always_ff @(posedge clock) begin
    if (launch) begin
      a_p1      <= bus.operand1;
      b_p1      <= bus.operand2;
      signed_p1 <= ~bus.operation[0];
    end
  end

  always_comb begin
    mul_a = signed_p1 ? {{DATA_W{a_p1[DATA_W-1]}}, a_p1} : {{DATA_W{1'b0}}, a_p1};
    mul_b = signed_p1 ? {{DATA_W{b_p1[DATA_W-1]}}, b_p1} : {{DATA_W{1'b0}}, b_p1};
    prod  = mul_a * mul_b;
  end

  assign div_zero = (b_p1 == '0);
  assign div_ovf  = signed_p1 && (a_p1 == 32'h8000_0000) && (b_p1 == 32'hFFFF_FFFF);

`ifdef MDU_ITERATIVE_DIV_EN
  logic [DATA_W-1:0] quo_p1, rem_p1, quo_n, rem_n, dmag;
  logic [DATA_W:0]   trial, diff;

  // One restoring step per cycle on magnitudes; the final step feeds the commit directly.
  always_comb begin
    dmag  = magnitude(b_p1, signed_p1);
    trial = {rem_p1, quo_p1[DATA_W-1]};
    diff  = trial - {1'b0, dmag};
    rem_n = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_n = {quo_p1[DATA_W-2:0], ~diff[DATA_W]};
  end

  always_ff @(posedge clock) begin
    if (launch) begin
      quo_p1 <= magnitude(bus.operand1, ~bus.operation[0]);
      rem_p1 <= '0;
    end else if (state == DIV) begin
      quo_p1 <= quo_n;
      rem_p1 <= rem_n;
    end
  end

  always_comb begin
    div_lo = negate_if(quo_n, signed_p1 && (a_p1[DATA_W-1] ^ b_p1[DATA_W-1]));
    div_hi = negate_if(rem_n, signed_p1 && a_p1[DATA_W-1]);
    if (div_zero) begin
      div_hi = a_p1;
      div_lo = '1;
    end else if (div_ovf) begin
      div_hi = '0;
      div_lo = 32'h8000_0000;
    end
  end
`else
  logic signed [DATA_W-1:0] sa, sb;

  // Zero divisor and signed overflow are muxed out so the operators never see them.
  always_comb begin
    sa     = a_p1;
    sb     = b_p1;
    div_hi = '0;
    div_lo = '0;
    if (div_zero) begin
      div_hi = a_p1;
      div_lo = '1;
    end else if (div_ovf) begin
      div_hi = '0;
      div_lo = 32'h8000_0000;
    end else if (signed_p1) begin
      div_lo = sa / sb;
      div_hi = sa % sb;
    end else begin
      div_lo = a_p1 / b_p1;
      div_hi = a_p1 % b_p1;
    end
  end
`endif

  assign res_hi = (state == MUL) ? prod[63:32] : div_hi;
  assign res_lo = (state == MUL) ? prod[31:0]  : div_lo;

  // p2: architectural HI/LO; a start in the same cycle suppresses an MTHI/MTLO
  always_ff @(posedge clock) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if ((state == IDLE) && bus.hilo_write && !launch) begin
      if (bus.operation == 3'd2) hi <= bus.operand1;
      if (bus.operation == 3'd3) lo <= bus.operand1;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.dataRead = (bus.operation == 3'd0) ? hi : lo;

endmodule

// File: tb/tb_mdu_responder.sv
// Scoreboard bench for mdu_responder: stimulus queues expected completions and reads, a negedge monitor checks them.
module tb_mdu_responder;

  logic clock;
  logic reset;
  mdu_responder_if bus();

  mdu_responder #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MDU_ITERATIVE_DIV_EN
  localparam int DLEN = 32;
`else
  localparam int DLEN = 10;
`endif
  localparam int MLEN = 5;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] lo;
  } done_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_busy;
  } rd_t;

  done_t done_q[$];
  rd_t   rd_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rd_en  = 1'b0;
  int    run    = 0;
  done_t d;
  rd_t   r;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: busy falling pops a completion; an armed read pops a read check.
  always @(negedge clock) begin
    if (bus.busy === 1'b1) begin
      run++;
    end else if (run > 0) begin
      if (done_q.size() == 0) begin
        chk("unexpected_busy_run", run, 0);
      end else begin
        d = done_q.pop_front();
        chk({d.name, "_busy_len"}, run, d.len);
        chk({d.name, "_lo_on_fall"}, bus.dataRead, d.lo);
      end
      run = 0;
    end
    if (rd_en) begin
      if (rd_q.size() == 0) begin
        chk("read_queue_underflow", 1, 0);
      end else begin
        r = rd_q.pop_front();
        if (r.is_busy) chk(r.name, {31'b0, bus.busy}, r.exp);
        else           chk(r.name, bus.dataRead, r.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [2:0] op, input string name, input logic [31:0] exp);
    bus.operation = op;
    rd_q.push_back('{name, exp, 1'b0});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd_busy(input string name, input logic exp);
    rd_q.push_back('{name, {31'b0, exp}, 1'b1});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 1, 0);
    tick();
  endtask

  task automatic hw(input logic [2:0] op, input logic [31:0] val);
    bus.operation  = op;
    bus.operand1   = val;
    bus.hilo_write = 1'b1;
    tick();
    bus.hilo_write = 1'b0;
  endtask

  task automatic long_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int len, input logic [31:0] hi_e,
                         input logic [31:0] lo_e);
    bus.operation = op;
    bus.operand1  = a;
    bus.operand2  = b;
    bus.start     = 1'b1;
    done_q.push_back('{name, len, lo_e});
    tick();
    bus.start     = 1'b0;
    bus.operation = 3'd1;
    wait_idle(name);
    rd(3'd0, {name, "_hi"}, hi_e);
  endtask

  initial begin
    reset          = 1'b0;
    bus.operand1   = 32'd6;
    bus.operand2   = 32'd7;
    bus.operation  = 3'd4;
    bus.start      = 1'b1;
    bus.hilo_write = 1'b0;
    repeat (2) tick();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.operation = 3'd0;
    rd_busy("reset_busy", 1'b0);
    rd(3'd0, "reset_hi", 32'h0);
    rd(3'd1, "reset_lo", 32'h0);
    rd_busy("start_in_reset_dropped", 1'b0);

    long_op("mult_neg2x3",  3'd4, 32'hFFFF_FFFE, 32'd3, MLEN, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    long_op("multu_neg2x3", 3'd5, 32'hFFFF_FFFE, 32'd3, MLEN, 32'h0000_0002, 32'hFFFF_FFFA);
    long_op("div_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2, DLEN, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("div_7_m2",     3'd6, 32'd7, 32'hFFFF_FFFE, DLEN, 32'h0000_0001, 32'hFFFF_FFFD);
    long_op("div_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, DLEN, 32'h0, 32'h8000_0000);
    long_op("divu_100_0",   3'd7, 32'd100, 32'd0, DLEN, 32'd100, 32'hFFFF_FFFF);
    long_op("div_m5_0",     3'd6, 32'hFFFF_FFFB, 32'd0, DLEN, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    long_op("divu_max_7",   3'd7, 32'hFFFF_FFFF, 32'd7, DLEN, 32'd3, 32'h2492_4924);

    // Start and write pulses while a multiply is in flight must be ignored.
    bus.operation = 3'd4;
    bus.operand1  = 32'd6;
    bus.operand2  = 32'd7;
    bus.start     = 1'b1;
    done_q.push_back('{"mult_6x7_busy_ignore", MLEN, 32'd42});
    tick();
    bus.start     = 1'b0;
    bus.operation = 3'd1;
    tick();
    bus.operation = 3'd7;
    bus.operand1  = 32'd9;
    bus.operand2  = 32'd3;
    bus.start     = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.operation  = 3'd2;
    bus.operand1   = 32'hDEAD_BEEF;
    bus.hilo_write = 1'b1;
    tick();
    bus.hilo_write = 1'b0;
    bus.operation  = 3'd1;
    wait_idle("mult_6x7_busy_ignore");
    rd(3'd0, "busy_ignore_hi", 32'h0);
    rd_busy("busy_ignore_no_second_op", 1'b0);

    hw(3'd3, 32'h1234_5678);
    rd(3'd1, "mtlo_readback", 32'h1234_5678);
    hw(3'd2, 32'h1111_1111);
    rd(3'd0, "mthi_readback", 32'h1111_1111);

    // start together with hilo_write: multiply result wins.
    bus.operation  = 3'd4;
    bus.operand1   = 32'd3;
    bus.operand2   = 32'd5;
    bus.start      = 1'b1;
    bus.hilo_write = 1'b1;
    done_q.push_back('{"start_wins", MLEN, 32'd15});
    tick();
    bus.start      = 1'b0;
    bus.hilo_write = 1'b0;
    bus.operation  = 3'd1;
    wait_idle("start_wins");
    rd(3'd0, "start_wins_hi", 32'h0);

    // Reset during a divide aborts it with HI/LO cleared and no late commit.
    hw(3'd2, 32'hAAAA_AAAA);
    hw(3'd3, 32'h5555_5555);
    rd(3'd0, "pre_abort_hi", 32'hAAAA_AAAA);
    rd(3'd1, "pre_abort_lo", 32'h5555_5555);
    bus.operation = 3'd6;
    bus.operand1  = 32'd100;
    bus.operand2  = 32'd7;
    bus.start     = 1'b1;
    done_q.push_back('{"reset_mid_div", 4, 32'h0});
    tick();
    bus.start     = 1'b0;
    bus.operation = 3'd1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd_busy("abort_busy", 1'b0);
    rd(3'd0, "abort_hi", 32'h0);
    repeat (12) tick();
    rd(3'd1, "abort_no_late_lo", 32'h0);
    rd(3'd0, "abort_no_late_hi", 32'h0);

    repeat (2) tick();
    chk("queues_drained", done_q.size() + rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_responder.md
# mdu_responder

Responder end of the pipeline's multiply/divide start/busy handshake. The EX stage issues an operation, two operands and a `start` pulse, then stalls on `busy`. This block latches the operands, runs the operation over a fixed or iterative number of cycles, holds the HI/LO architectural registers, and returns HI or LO combinationally on `dataRead` for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU when `MDU_ITERATIVE_DIV_EN` is undefined; must be ≥1.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `operand1` in 32: rs value, the dividend for division.
- `operand2` in 32: rt value, the divisor for division.
- `operation` in 3: opcode. 0 READ_HI, 1 READ_LO, 2 WRITE_HI, 3 WRITE_LO, 4 MULT, 5 MULTU, 6 DIV, 7 DIVU.
- `start` in 1: launch a long op; valid only with `operation` 4–7.
- `hilo_write` in 1: MTHI/MTLO strobe; valid only with `operation` 2–3.
- `busy` out 1: long op in flight.
- `dataRead` out 32: HI when `operation`=0, otherwise LO.

## Operation
- States: IDLE, MUL, DIV.
- **IDLE + `start`:**
  - latch `operand1`, `operand2` and the signed/unsigned flag;
  - load the cycle counter;
  - go to MUL (ops 4/5) or DIV (ops 6/7).
- **IDLE + `hilo_write`:** write `operand1` into HI (op 2) or LO (op 3). No busy period.
- **MUL/DIV:**
  - decrement the counter each cycle;
  - on the cycle the counter reaches its final count, write HI/LO and return to IDLE.
- **Multiply result:** 64-bit product of the latched operands; HI = product[63:32], LO = product[31:0]. MULT is signed, MULTU is unsigned.
- **Divide result:** LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- **Divisor zero:** HI = latched dividend, LO = 32'hFFFF_FFFF, for both DIV and DIVU.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** LO = 0x8000_0000, HI = 0.
- **`start` or `hilo_write` while `busy`=1:** ignored. HI/LO and the in-flight op are unaffected.
- **`start` and `hilo_write` together in IDLE:** `start` wins and the write is dropped.
- **`dataRead`:** combinational from the HI/LO registers. While busy it returns the pre-op values.
- **Reset mid-operation:** the op is aborted with no HI/LO update.

## Timing
- **Reset (`reset`=0 at an edge):**
  - HI = 0, LO = 0, `busy` = 0, state = IDLE, counter = 0;
  - all outputs are valid on the following cycle.
- **`busy` profile:** `start` sampled at edge T gives `busy`=1 from T+1 through T+N, where N is the configured latency.
  - HI/LO update at edge T+N; `busy`=0 after T+N.
  - The new HI/LO are visible on `dataRead` in the same cycle that `busy` falls.
- **Back-to-back ops:** a new `start` is accepted at edge T+N+1 at the earliest, i.e. the first cycle with `busy`=0.
- **`hilo_write` at edge T:** HI/LO are updated by edge T+1. `dataRead` reflects the new value from T+1.
- **Operand capture:** operands are captured only at the `start` edge. Later changes on `operand1`/`operand2` have no effect.
- **No interrupt/cancel input:** the hazard unit guarantees `start` is never asserted while `busy`.

## Configuration
- **Macro:** `MDU_ITERATIVE_DIV_EN`.
- **Defined:**
  - divides use a radix-2 restoring shift-subtract on operand magnitudes, with a sign fix-up of quotient and remainder;
  - one bit per cycle, so N = 32 for DIV/DIVU, and `DIV_CYCLES` is ignored;
  - divisor zero and overflow results must still match the Operation rules exactly.
- **Undefined:**
  - divide uses the combinational `/` and `%` operators on latched operands, with explicit zero/overflow muxing;
  - the result is held in a register and committed after `DIV_CYCLES` cycles.
- MULT latency is `MULT_CYCLES` in both builds.

## Test plan
- **Reset:** drive `reset`=0 for 2 cycles, then 1 → `busy`=0, READ_HI=0, READ_LO=0; `start` during reset is not accepted.
- **MULT:** `operand1`=0xFFFF_FFFE (−2), `operand2`=3, `start` pulse → `busy` high exactly 5 cycles; then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. The same operands with MULTU → HI=0x0000_0002, LO=0xFFFF_FFFA.
- **DIV:** `operand1`=−7, `operand2`=2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1) after 10 cycles, or 32 cycles with the macro. Also check DIV 0x8000_0000/−1 → LO=0x8000_0000, HI=0, and DIVU 100/0 → HI=100, LO=0xFFFF_FFFF.
- **Ignored inputs while busy:** start MULT 6×7; at busy cycle 2 pulse `start` (DIVU 9/3) and `hilo_write` (WRITE_HI, 0xDEAD_BEEF) → final HI=0, LO=42, and `busy` still falls after 5 cycles.
- **MTHI/MTLO:** WRITE_LO 0x1234_5678, then next cycle READ_LO → 0x1234_5678. `start` and `hilo_write` in the same cycle → the multiply result wins and the write is lost.
- **Reset mid-op:** after HI=0xAAAA_AAAA/LO=0x5555_5555 are set, start DIV 100/7; assert `reset` at busy cycle 4 → `busy`=0, HI=LO=0, no late update on later cycles.
